// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int REG_ADDR_W           = 5;
    localparam int DEFAULT_DRAIN_CYCLES = 3;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        MDU_REQ  = 3'd1,
        MDU_WAIT = 3'd2,
        DRAIN    = 3'd3,
        HALTED   = 3'd4
    } hz_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  id_ex_mem_read,
    output logic                  hazard
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_use_rs1 && (id_ex_rd == id_rs1);
    assign rs2_match = id_use_rs2 && (id_ex_rd == id_rs2);

    // x0 is hardwired zero, so a load targeting it never produces a dependency.
    assign hazard = id_ex_mem_read && (id_ex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer: load-use, MDU handshake, mispredict flush and ecall drain/halt.
module pipeline_hazard_controller
    import hazard_pkg::*;
#(
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_halt_req,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  id_ex_mem_read,
    input  logic                  id_ex_is_mdu,
    input  logic                  ex_mispredict,
    input  logic                  mdu_ready,
    input  logic                  mdu_done,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  ex_hold,
    output logic                  mdu_req,
    output logic                  is_halted,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    hz_state_t            state_reg, state_next;
    logic [DRAIN_W-1:0]   drain_cnt_reg;
    logic [CNT_WIDTH-1:0] stall_count_reg;
    logic                 load_use;

    load_use_detect u_load_use_detect (
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .id_ex_rd       (id_ex_rd),
        .id_ex_mem_read (id_ex_mem_read),
        .hazard         (load_use)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= RUN;
            drain_cnt_reg   <= '0;
            stall_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == RUN)
                drain_cnt_reg <= '0;
            else if (state_reg == DRAIN)
                drain_cnt_reg <= drain_cnt_reg + 1'b1;
            // Saturating: a wrapped counter would misreport long stalls as short ones.
            if (!pc_write && (state_reg != HALTED) && (stall_count_reg != '1))
                stall_count_reg <= stall_count_reg + 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN: begin
                if (ex_mispredict)
                    state_next = RUN;
                else if (id_ex_is_mdu)
                    state_next = mdu_ready ? MDU_WAIT : MDU_REQ;
                else if (load_use)
                    state_next = RUN;
                else if (id_halt_req)
                    state_next = DRAIN;
            end
            MDU_REQ:  if (mdu_ready) state_next = MDU_WAIT;
            MDU_WAIT: if (mdu_done)  state_next = RUN;
            DRAIN:    if (drain_cnt_reg == DRAIN_LAST) state_next = HALTED;
            HALTED:   state_next = HALTED;
            default:  state_next = RUN;
        endcase
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        mdu_req      = 1'b0;
        is_halted    = 1'b0;
        if (!reset_n) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    // The ID instruction is wrong-path under a mispredict, so its hazards are moot.
                    if (ex_mispredict) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (id_ex_is_mdu) begin
                        mdu_req     = 1'b1;
                        ex_hold     = 1'b1;
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                    end else if (load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else if (id_halt_req) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                    end
                end
                MDU_REQ: begin
                    mdu_req     = 1'b1;
                    ex_hold     = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                end
                MDU_WAIT: begin
                    if (!mdu_done) begin
                        ex_hold     = 1'b1;
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                    end
                end
                DRAIN: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
                HALTED: begin
                    is_halted    = 1'b1;
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
                default: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                end
            endcase
        end
    end

    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector bench for pipeline_hazard_controller; a 4-bit-counter twin covers saturation.
module tb_pipeline_hazard_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  id_rs1, id_rs2, id_ex_rd;
    logic        id_use_rs1, id_use_rs2, id_halt_req;
    logic        id_ex_mem_read, id_ex_is_mdu, ex_mispredict, mdu_ready, mdu_done;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, mdu_req, is_halted;
    logic [31:0] stall_count;
    logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_ex_hold, s_mdu_req, s_is_halted;
    logic [3:0]  s_stall_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_halt_req(id_halt_req), .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_is_mdu(id_ex_is_mdu), .ex_mispredict(ex_mispredict),
        .mdu_ready(mdu_ready), .mdu_done(mdu_done),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .ex_hold(ex_hold), .mdu_req(mdu_req),
        .is_halted(is_halted), .stall_count(stall_count)
    );

    pipeline_hazard_controller #(.CNT_WIDTH(4)) dut_sat (
        .clk(clk), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_halt_req(id_halt_req), .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_is_mdu(id_ex_is_mdu), .ex_mispredict(ex_mispredict),
        .mdu_ready(mdu_ready), .mdu_done(mdu_done),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
        .id_ex_bubble(s_id_ex_bubble), .ex_hold(s_ex_hold), .mdu_req(s_mdu_req),
        .is_halted(s_is_halted), .stall_count(s_stall_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance one cycle; inputs change at edge+1, outputs are sampled at edge+3.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; id_ex_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_halt_req = 0;
        id_ex_mem_read = 0; id_ex_is_mdu = 0; ex_mispredict = 0;
        mdu_ready = 0; mdu_done = 0;
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        #1;
        check("rst_pc_write", pc_write, 0);
        check("rst_stall_count", stall_count, 0);
        check("rst_mdu_req", mdu_req, 0);
        tick(); tick();
        reset_n = 1'b1;
        settle();
        check("idle_pc_write", pc_write, 1);
        check("idle_if_id_write", if_id_write, 1);
        check("idle_is_halted", is_halted, 0);

        // Load-use on rs2
        tick();
        id_ex_mem_read = 1; id_ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1;
        settle();
        check("lu_pc_write", pc_write, 0);
        check("lu_if_id_write", if_id_write, 0);
        check("lu_bubble", id_ex_bubble, 1);
        tick();
        clear_inputs();
        settle();
        check("lu_after_pc_write", pc_write, 1);
        check("lu_stall_count", stall_count, 1);
        $display("txn load_use rd=5 rs2=5: stall_count=%0d", stall_count);

        // Load to x0 never stalls
        tick();
        id_ex_mem_read = 1; id_ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1;
        settle();
        check("x0_pc_write", pc_write, 1);
        check("x0_bubble", id_ex_bubble, 0);
        tick();
        clear_inputs();
        settle();
        check("x0_stall_count", stall_count, 1);
        $display("txn load_use rd=0: stall_count=%0d", stall_count);

        // MDU: ready low two cycles, accepted on third, four wait cycles, then done
        tick();
        id_ex_is_mdu = 1;
        for (int i = 0; i < 3; i++) begin
            mdu_ready = (i == 2);
            settle();
            check("mdu_req_phase", mdu_req, 1);
            check("mdu_req_hold", ex_hold, 1);
            check("mdu_req_pc_write", pc_write, 0);
            tick();
        end
        id_ex_is_mdu = 0; mdu_ready = 0;
        for (int i = 0; i < 4; i++) begin
            ex_mispredict = (i == 1);
            settle();
            check("mdu_wait_req", mdu_req, 0);
            check("mdu_wait_hold", ex_hold, 1);
            check("mdu_wait_flush", if_id_flush, 0);
            tick();
        end
        ex_mispredict = 0; mdu_done = 1;
        settle();
        check("mdu_done_hold", ex_hold, 0);
        check("mdu_done_pc_write", pc_write, 1);
        check("mdu_done_if_id_write", if_id_write, 1);
        tick();
        clear_inputs();
        settle();
        check("mdu_stall_count", stall_count, 8);
        check("mdu_back_run", pc_write, 1);
        $display("txn mdu 3req+4wait: stall_count=%0d", stall_count);

        // Mispredict overrides load-use and halt request
        tick();
        ex_mispredict = 1; id_halt_req = 1;
        id_ex_mem_read = 1; id_ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1;
        settle();
        check("mp_flush", if_id_flush, 1);
        check("mp_bubble", id_ex_bubble, 1);
        check("mp_pc_write", pc_write, 1);
        tick();
        clear_inputs();
        settle();
        check("mp_still_run", pc_write, 1);
        check("mp_stall_count", stall_count, 8);
        $display("txn mispredict+hazard+halt: stall_count=%0d", stall_count);

        // Reset in the middle of an MDU request
        tick();
        id_ex_is_mdu = 1;
        tick();
        id_ex_is_mdu = 0;
        settle();
        check("mid_mdu_req", mdu_req, 1);
        reset_n = 1'b0;
        #1;
        check("rstmid_mdu_req", mdu_req, 0);
        check("rstmid_stall_count", stall_count, 0);
        tick();
        reset_n = 1'b1;
        settle();
        check("rstmid_pc_write", pc_write, 1);
        check("rstmid_req_after", mdu_req, 0);
        $display("txn reset during MDU_REQ: stall_count=%0d", stall_count);

        // Saturation: 20 stalled cycles on the 4-bit twin
        tick();
        id_ex_is_mdu = 1;
        for (int i = 0; i < 20; i++) tick();
        settle();
        check("sat_main_count", stall_count, 20);
        check("sat_small_count", s_stall_count, 15);
        mdu_ready = 1;
        tick();
        id_ex_is_mdu = 0; mdu_ready = 0; mdu_done = 1;
        settle();
        check("sat_done_pc_write", pc_write, 1);
        tick();
        clear_inputs();
        settle();
        check("sat_main_after", stall_count, 21);
        check("sat_small_after", s_stall_count, 15);
        $display("txn saturation: stall_count=%0d small=%0d", stall_count, s_stall_count);

        // Halt: ecall advances, three drain cycles, then sticky halt
        tick();
        id_halt_req = 1;
        settle();
        check("halt_pc_write", pc_write, 0);
        check("halt_bubble", id_ex_bubble, 0);
        tick();
        id_halt_req = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("drain_bubble", id_ex_bubble, 1);
            check("drain_halted", is_halted, 0);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            ex_mispredict = i[0]; id_ex_is_mdu = i[1]; mdu_ready = i[2]; mdu_done = i[0];
            settle();
            check("halted_flag", is_halted, 1);
            check("halted_mdu_req", mdu_req, 0);
            check("halted_flush", if_id_flush, 0);
            tick();
        end
        clear_inputs();
        settle();
        check("halted_stall_count", stall_count, 25);
        check("halted_pc_write", pc_write, 0);
        $display("txn halt+drain: stall_count=%0d", stall_count);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Consumes ID/EX/MEM hazard information that operand forwarding cannot resolve:
  - load-use hazards
  - the multi-cycle MUL/DIV unit (MDU) request/done handshake
  - EX-stage branch mispredicts
  - ecall-driven halt with pipeline drain
- Drives PC/IF-ID write enables, bubble/flush controls, the MDU request, the halt flag and a stall-cycle counter.

Parameters:
- DRAIN_CYCLES, 3: cycles of bubble insertion after ecall leaves ID, before is_halted asserts (covers EX, MEM, WB).
- CNT_WIDTH, 32: width of stall_count.

Ports:
- clk  input  1  pipeline clock
- reset_n  input  1  asynchronous, active-low reset
- id_rs1  input  5  ID-stage source register 1
- id_rs2  input  5  ID-stage source register 2
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- id_halt_req  input  1  ID holds an ecall that halts
- id_ex_rd  input  5  EX-stage destination register
- id_ex_mem_read  input  1  EX-stage instruction is a load
- id_ex_is_mdu  input  1  EX-stage instruction is a MUL/DIV op
- ex_mispredict  input  1  EX branch/jump resolved as mispredicted
- mdu_ready  input  1  MDU accepts request
- mdu_done  input  1  MDU result valid, one-cycle pulse
- pc_write  output  1  PC register write enable
- if_id_write  output  1  IF/ID write enable
- if_id_flush  output  1  zero IF/ID at the next edge
- id_ex_bubble  output  1  load a NOP into ID/EX
- ex_hold  output  1  hold ID/EX contents; load a NOP into EX/MEM
- mdu_req  output  1  MDU start request
- is_halted  output  1  pipeline halted
- stall_count  output  CNT_WIDTH  cycles with pc_write=0 while running

Behaviour:
- FSM states: RUN, MDU_REQ, MDU_WAIT, DRAIN, HALTED. Async reset -> RUN, drain counter 0, stall_count 0.
- While reset_n=0, all outputs are 0. mdu_req drops immediately on reset, including mid-handshake.
- Outputs are combinational from state and inputs (Moore/Mealy mix). Default values: pc_write=1, if_id_write=1, all other controls 0.
- RUN, evaluated in this priority order:
  1. ex_mispredict=1: if_id_flush=1, id_ex_bubble=1, pc_write=1. id_halt_req and any load-use hazard are ignored, because the ID instruction is wrong-path.
  2. id_ex_is_mdu=1: mdu_req=1, ex_hold=1, pc_write=0, if_id_write=0. Next state is MDU_WAIT if mdu_ready=1, else MDU_REQ.
  3. Load-use: id_ex_mem_read && id_ex_rd!=0 && ((id_ex_rd==id_rs1 && id_use_rs1) || (id_ex_rd==id_rs2 && id_use_rs2)). Response: pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly one cycle (the hazard clears naturally).
  4. id_halt_req=1: the ecall advances normally this cycle; pc_write=0, if_id_write=0; next state DRAIN, counter cleared.
- MDU_REQ:
  - Outputs: mdu_req=1, ex_hold=1, pc_write=0, if_id_write=0.
  - mdu_ready=1 -> MDU_WAIT.
- MDU_WAIT:
  - Outputs: mdu_req=0, ex_hold=1, pc_write=0, if_id_write=0.
  - On mdu_done=1: same cycle ex_hold=0, pc_write=1, if_id_write=1, so the result latches into EX/MEM. Next state RUN.
  - mdu_done in the same cycle as acceptance is illegal and is not sampled in MDU_REQ.
- ex_mispredict is ignored in MDU_REQ and MDU_WAIT: EX holds the MDU op, not a branch.
- DRAIN:
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1. Counter increments each cycle.
  - When counter==DRAIN_CYCLES-1 -> HALTED.
  - No MDU op can be in EX during DRAIN, because ecall only enters EX from RUN with no hold. Other inputs are ignored.
- HALTED:
  - Outputs: is_halted=1, pc_write=0, if_id_write=0, id_ex_bubble=1.
  - Sticky until reset.
- stall_count:
  - Increments on each clock where pc_write=0 and state!=HALTED.
  - Saturates at all-ones, no wrap.
  - Mispredict cycles do not count.
- x0 never causes a load-use stall.

Decomposition:
- Shared package hazard_pkg:
  - state enum (RUN, MDU_REQ, MDU_WAIT, DRAIN, HALTED)
  - REG_ADDR_W=5
  - default DRAIN_CYCLES
- One natural sub-module: load_use_detect, purely combinational. Inputs are rs1/rs2/use flags, id_ex_rd and id_ex_mem_read; output is hazard.
- The FSM, drain counter and stall counter stay in the top module.

Test Plan:
- Load-use: id_ex_mem_read=1, id_ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count 0->1. Same stimulus with id_ex_rd=0 -> no stall.
- MDU: id_ex_is_mdu=1, mdu_ready low for 2 cycles then high, mdu_done 4 cycles later -> mdu_req high for 3 cycles, then low; ex_hold high until the done cycle, low in the done cycle; stall_count +7.
- Mispredict with simultaneous load-use hazard and id_halt_req=1 -> if_id_flush=1, id_ex_bubble=1, pc_write=1; state stays RUN; stall_count unchanged.
- Halt: id_halt_req=1 in RUN -> DRAIN for 3 cycles with id_ex_bubble=1, then is_halted=1 held for 20 cycles despite ex_mispredict/mdu inputs toggling.
- Reset mid-operation: reset_n low during MDU_REQ -> mdu_req=0 immediately, stall_count=0. After release, state RUN with pc_write=1.
- Saturation: CNT_WIDTH=4 with 20 consecutive MDU stall cycles -> stall_count holds 15.
